// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data memory responder with a fixed,
// parameterised request-to-response latency and misalignment reporting.
//
// Handshake: a request transfers at a rising edge where req_valid=1 and
// req_ready=1; a response transfers at a rising edge where resp_valid=1 and
// resp_ready=1. Once raised, resp_valid and its payload hold until that
// transfer (or reset). req_ready and resp_valid are never high together.
module dmem_responder #(
   parameter int LATENCY     = 4,
   parameter int DEPTH_WORDS = 16384
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [1:0]  dbg_state
);

   localparam int IW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic [3:0] cnt;

   logic          lat_write, lat_mis;
   logic [IW-1:0] lat_idx;
   logic [31:0]   lat_wdata;

   logic          cur_write, cur_mis;
   logic [IW-1:0] cur_idx;
   logic [31:0]   cur_wdata;

   logic          accept, enter_resp;
   logic          unused_addr_hi;

   logic [31:0] mem [DEPTH_WORDS];

   // Upper address bits are deliberately ignored so addresses wrap.
   assign unused_addr_hi = ^req_addr[31:IW+2];

   // Next-state decode; the counter gates the BUSY -> RESP transition.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req_valid) state_nxt = (LATENCY == 1) ? RESP : BUSY;
         BUSY: if (cnt == 4'd0) state_nxt = RESP;
         RESP: if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // With LATENCY=1 the response is formed at the acceptance edge itself, so
   // the live request fields are used while IDLE and the latched copy after.
   always_comb begin
      accept     = (state == IDLE) && req_valid;
      enter_resp = (state != RESP) && (state_nxt == RESP);
      if (state == IDLE) begin
         cur_write = req_write;
         cur_mis   = (req_addr[1:0] != 2'b00);
         cur_idx   = req_addr[IW+1:2];
         cur_wdata = req_wdata;
      end else begin
         cur_write = lat_write;
         cur_mis   = lat_mis;
         cur_idx   = lat_idx;
         cur_wdata = lat_wdata;
      end
   end

   // State register and latency down-counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         if (accept)
            cnt <= CNT_LOAD;
         else if (state == BUSY && cnt != 4'd0)
            cnt <= cnt - 4'd1;
      end
   end

   // Capture the request at acceptance so later input changes are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         lat_write <= 1'b0;
         lat_mis   <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= '0;
      end else if (accept) begin
         lat_write <= req_write;
         lat_mis   <= (req_addr[1:0] != 2'b00);
         lat_idx   <= req_addr[IW+1:2];
         lat_wdata <= req_wdata;
      end
   end

   // Storage access and response payload, both performed on entry to RESP.
   always_ff @(posedge clk) begin
      if (reset) begin
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
         for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
      end else if (enter_resp) begin
         if (cur_mis) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b1;
         end else if (cur_write) begin
            mem[cur_idx] <= cur_wdata;
            resp_rdata   <= 32'd0;
            resp_err     <= 1'b0;
         end else begin
            resp_rdata <= mem[cur_idx];
            resp_err   <= 1'b0;
         end
      end
   end

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign dbg_state  = state;

endmodule
